// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared opcode encodings, FSM state encoding and result constants
//            for the EX-stage multiply/divide controller.
// Contents : MD_* opcodes, md_state_e, DIV0_LO
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Mul/div opcode encodings carried on i_md_op
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // LO value produced by a divide by zero
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/ex_muldiv_core.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_core
// Purpose  : One radix-2 iteration of the mul/div datapath, purely
//            combinational. The accumulator {hi,lo} is shared:
//              multiply : hi = partial product, lo = remaining multiplier bits
//              divide   : hi = partial remainder, lo = dividend/quotient bits
// Ports    : i_is_div  - select restoring-divide step (else shift-add)
//            i_acc_hi  - accumulator upper half
//            i_acc_lo  - accumulator lower half
//            i_opnd    - multiplicand (multiply) or divisor (divide) magnitude
//            o_acc_hi  - next accumulator upper half
//            o_acc_lo  - next accumulator lower half
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_core #(
    parameter int NB_REG = 32
) (
    input  logic              i_is_div,
    input  logic [NB_REG-1:0] i_acc_hi,
    input  logic [NB_REG-1:0] i_acc_lo,
    input  logic [NB_REG-1:0] i_opnd,
    output logic [NB_REG-1:0] o_acc_hi,
    output logic [NB_REG-1:0] o_acc_lo
);

    logic [NB_REG:0] w_sum;
    logic [NB_REG:0] w_mul_upper;
    logic [NB_REG:0] w_rem_sh;
    logic [NB_REG:0] w_diff;

    always_comb begin
        // Shift-add: conditionally add the multiplicand, then shift the
        // 2*NB_REG+1 bit {carry,hi,lo} right by one.
        w_sum       = {1'b0, i_acc_hi} + {1'b0, i_opnd};
        w_mul_upper = i_acc_lo[0] ? w_sum : {1'b0, i_acc_hi};

        // Restoring divide: shift the next dividend bit into the remainder
        // and keep the difference only when it does not go negative.
        w_rem_sh = {i_acc_hi, i_acc_lo[NB_REG-1]};
        w_diff   = w_rem_sh - {1'b0, i_opnd};

        if (i_is_div) begin
            if (!w_diff[NB_REG]) begin
                o_acc_hi = w_diff[NB_REG-1:0];
                o_acc_lo = {i_acc_lo[NB_REG-2:0], 1'b1};
            end else begin
                o_acc_hi = w_rem_sh[NB_REG-1:0];
                o_acc_lo = {i_acc_lo[NB_REG-2:0], 1'b0};
            end
        end else begin
            o_acc_hi = w_mul_upper[NB_REG:1];
            o_acc_lo = {w_mul_upper[0], i_acc_lo[NB_REG-1:1]};
        end
    end

endmodule : ex_muldiv_core
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_ctrl
// Purpose  : Iterative MULT/MULTU/DIV/DIVU controller for the EX stage; owns
//            the HI/LO pair and stalls the front of the pipe while running.
// Ports    : i_clk, i_rst_n       - clock, async active-low reset
//            i_start, i_md_op     - mul/div request and opcode
//            i_rs_data, i_rt_data - forwarded operands
//            i_wr_hi, i_wr_lo     - MTHI/MTLO enables, data on i_wdata
//            i_flush              - synchronous abort
//            o_stall              - freeze IF/ID/EX (combinational)
//            o_busy, o_done       - registered status
//            o_hi, o_lo           - architectural HI/LO
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_CNT  = 6,
    parameter int NB_MDOP = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_MDOP-1:0] i_md_op,
    input  logic [NB_REG-1:0]  i_rs_data,
    input  logic [NB_REG-1:0]  i_rt_data,
    input  logic               i_wr_hi,
    input  logic               i_wr_lo,
    input  logic [NB_REG-1:0]  i_wdata,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_REG-1:0]  o_hi,
    output logic [NB_REG-1:0]  o_lo
);

    md_state_e           r_state_q,  w_state_d;
    logic [NB_CNT-1:0]   r_cnt_q,    w_cnt_d;
    logic                r_is_div_q, w_is_div_d;
    logic                r_neg_q,    w_neg_d;     // operand signs differ
    logic                r_rs_neg_q, w_rs_neg_d;  // dividend negative
    logic                r_div0_q,   w_div0_d;
    logic [NB_REG-1:0]   r_opnd_q,   w_opnd_d;
    logic [NB_REG-1:0]   r_rs_q,     w_rs_d;      // raw dividend for div-by-0
    logic [NB_REG-1:0]   r_acc_hi_q, w_acc_hi_d;
    logic [NB_REG-1:0]   r_acc_lo_q, w_acc_lo_d;
    logic [NB_REG-1:0]   r_hi_q,     w_hi_d;
    logic [NB_REG-1:0]   r_lo_q,     w_lo_d;
    logic                r_busy_q,   w_busy_d;
    logic                r_done_q,   w_done_d;

    logic                w_accept;
    logic                w_op_div;
    logic                w_op_signed;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [NB_REG-1:0]   w_rs_mag;
    logic [NB_REG-1:0]   w_rt_mag;
    logic [2*NB_REG-1:0] w_prod;
    logic [2*NB_REG-1:0] w_prod_fix;
    logic [NB_REG-1:0]   w_quo_fix;
    logic [NB_REG-1:0]   w_rem_fix;
    logic [2*NB_REG-1:0] w_res;
    logic [NB_REG-1:0]   w_step_hi;
    logic [NB_REG-1:0]   w_step_lo;

    ex_muldiv_core #(
        .NB_REG (NB_REG)
    ) u_core (
        .i_is_div (r_is_div_q),
        .i_acc_hi (r_acc_hi_q),
        .i_acc_lo (r_acc_lo_q),
        .i_opnd   (r_opnd_q),
        .o_acc_hi (w_step_hi),
        .o_acc_lo (w_step_lo)
    );

    always_comb begin
        w_accept    = (r_state_q == ST_IDLE) && i_start && !i_flush;
        w_op_div    = (i_md_op == MD_DIV)  || (i_md_op == MD_DIVU);
        w_op_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
        w_rs_neg    = w_op_signed && i_rs_data[NB_REG-1];
        w_rt_neg    = w_op_signed && i_rt_data[NB_REG-1];
        w_rs_mag    = w_rs_neg ? -i_rs_data : i_rs_data;
        w_rt_mag    = w_rt_neg ? -i_rt_data : i_rt_data;

        // Sign correction of the magnitude result
        w_prod     = {r_acc_hi_q, r_acc_lo_q};
        w_prod_fix = r_neg_q    ? -w_prod     : w_prod;
        w_quo_fix  = r_neg_q    ? -r_acc_lo_q : r_acc_lo_q;
        w_rem_fix  = r_rs_neg_q ? -r_acc_hi_q : r_acc_hi_q;

        if (!r_is_div_q) begin
            w_res = w_prod_fix;
        end else if (r_div0_q) begin
            w_res = {r_rs_q, NB_REG'(DIV0_LO)};
        end else begin
            w_res = {w_rem_fix, w_quo_fix};
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_is_div_d = r_is_div_q;
        w_neg_d    = r_neg_q;
        w_rs_neg_d = r_rs_neg_q;
        w_div0_d   = r_div0_q;
        w_opnd_d   = r_opnd_q;
        w_rs_d     = r_rs_q;
        w_acc_hi_d = r_acc_hi_q;
        w_acc_lo_d = r_acc_lo_q;
        w_hi_d     = r_hi_q;
        w_lo_d     = r_lo_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d  = ST_CALC;
                    w_cnt_d    = '0;
                    w_is_div_d = w_op_div;
                    w_neg_d    = w_rs_neg ^ w_rt_neg;
                    w_rs_neg_d = w_rs_neg;
                    w_div0_d   = (i_rt_data == '0);
                    w_rs_d     = i_rs_data;
                    w_acc_hi_d = '0;
                    // Multiply shifts the multiplier out of lo; divide
                    // shifts the dividend out of lo.
                    w_acc_lo_d = w_op_div ? w_rs_mag : w_rt_mag;
                    w_opnd_d   = w_op_div ? w_rt_mag : w_rs_mag;
                end
            end
            ST_CALC: begin
                w_acc_hi_d = w_step_hi;
                w_acc_lo_d = w_step_lo;
                w_cnt_d    = r_cnt_q + NB_CNT'(1);
                if (r_cnt_q == NB_CNT'(NB_REG - 1)) begin
                    w_state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_d = ST_DONE;
                // Result commits on the DONE-entry edge unless aborted
                if (!i_flush) begin
                    w_hi_d = w_res[2*NB_REG-1:NB_REG];
                    w_lo_d = w_res[NB_REG-1:0];
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (i_flush) begin
            w_state_d = ST_IDLE;
        end

        // MTHI/MTLO take priority over a coincident result write
        if (i_wr_hi) begin
            w_hi_d = i_wdata;
        end
        if (i_wr_lo) begin
            w_lo_d = i_wdata;
        end

        w_busy_d = (w_state_d != ST_IDLE);
        w_done_d = (w_state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= '0;
            r_is_div_q <= 1'b0;
            r_neg_q    <= 1'b0;
            r_rs_neg_q <= 1'b0;
            r_div0_q   <= 1'b0;
            r_opnd_q   <= '0;
            r_rs_q     <= '0;
            r_acc_hi_q <= '0;
            r_acc_lo_q <= '0;
            r_hi_q     <= '0;
            r_lo_q     <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_is_div_q <= w_is_div_d;
            r_neg_q    <= w_neg_d;
            r_rs_neg_q <= w_rs_neg_d;
            r_div0_q   <= w_div0_d;
            r_opnd_q   <= w_opnd_d;
            r_rs_q     <= w_rs_d;
            r_acc_hi_q <= w_acc_hi_d;
            r_acc_lo_q <= w_acc_lo_d;
            r_hi_q     <= w_hi_d;
            r_lo_q     <= w_lo_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
        end
    end

    assign o_stall = w_accept || (r_state_q == ST_CALC) || (r_state_q == ST_FIX);
    assign o_busy  = r_busy_q;
    assign o_done  = r_done_q;
    assign o_hi    = r_hi_q;
    assign o_lo    = r_lo_q;

endmodule : ex_muldiv_ctrl
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_ctrl
// Purpose  : Self-checking bench for ex_muldiv_ctrl. Expected {HI,LO} values
//            are queued when an operation is launched and compared whenever
//            the controller pulses o_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_md_op;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_wr_hi;
    logic        i_wr_lo;
    logic [31:0] i_wdata;
    logic        i_flush;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    int          n_push   = 0;
    logic [63:0] sb_q[$];

    ex_muldiv_ctrl #(
        .NB_REG  (32),
        .NB_CNT  (6),
        .NB_MDOP (2)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_md_op   (i_md_op),
        .i_rs_data (i_rs_data),
        .i_rt_data (i_rt_data),
        .i_wr_hi   (i_wr_hi),
        .i_wr_lo   (i_wr_lo),
        .i_wdata   (i_wdata),
        .i_flush   (i_flush),
        .o_stall   (o_stall),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_hi      (o_hi),
        .o_lo      (o_lo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference {HI,LO} from plain SystemVerilog arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt);
        logic signed [63:0] sp;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic [63:0]        res;
        case (op)
            2'b00: begin
                sp  = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
                res = sp;
            end
            2'b01: res = {32'h0, rs} * {32'h0, rt};
            2'b10: begin
                if (rt == 32'h0) begin
                    res = {rs, 32'hFFFF_FFFF};
                end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                    res = {32'h0, 32'h8000_0000};
                end else begin
                    sq  = $signed(rs) / $signed(rt);
                    sr  = $signed(rs) % $signed(rt);
                    res = {sr, sq};
                end
            end
            default: begin
                if (rt == 32'h0) res = {rs, 32'hFFFF_FFFF};
                else             res = {rs % rt, rs / rt};
            end
        endcase
        return res;
    endfunction

    // Scoreboard consumer: every o_done must match the oldest queued result
    always @(negedge i_clk) begin
        if (i_rst_n && o_done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] exp;
                exp = sb_q.pop_front();
                check_val("result_hi", {32'h0, o_hi}, {32'h0, exp[63:32]});
                check_val("result_lo", {32'h0, o_lo}, {32'h0, exp[31:0]});
            end
        end
    end

    // Launch one op in the cycle after the next edge, hold i_start until the
    // stall drops, and check stall/busy/done timing against a 34-cycle run.
    task automatic do_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input bit mtlo_on_result);
        logic [63:0] exp;
        int n;
        @(posedge i_clk); #1;
        i_start   = 1'b1;
        i_md_op   = op;
        i_rs_data = rs;
        i_rt_data = rt;
        exp = model(op, rs, rt);
        if (mtlo_on_result) exp[31:0] = 32'h0000_00AA;
        sb_q.push_back(exp);
        n_push++;
        for (n = 0; n < 60; n++) begin
            #1;
            check_val("stall", {63'h0, o_stall}, {63'h0, (n <= 33)});
            if (n == 1 || n == 34) check_val("busy", {63'h0, o_busy}, 64'd1);
            if (n == 33 && mtlo_on_result) begin
                i_wr_lo = 1'b1;
                i_wdata = 32'h0000_00AA;
            end
            if (n == 34) i_wr_lo = 1'b0;
            if (!o_stall) break;
            @(posedge i_clk); #1;
        end
        if (n >= 60) begin
            check_val("op_timeout", 64'd1, 64'd0);
        end else begin
            check_val("done_latency", 64'(n), 64'd34);
            check_val("done_pulse", {63'h0, o_done}, 64'd1);
        end
        i_start = 1'b0;
        i_wr_lo = 1'b0;
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_md_op   = 2'b00;
        i_rs_data = '0;
        i_rt_data = '0;
        i_wr_hi   = 1'b0;
        i_wr_lo   = 1'b0;
        i_wdata   = '0;
        i_flush   = 1'b0;

        #12;
        check_val("rst_stall", {63'h0, o_stall}, 64'd0);
        check_val("rst_busy",  {63'h0, o_busy},  64'd0);
        check_val("rst_done",  {63'h0, o_done},  64'd0);
        check_val("rst_hilo",  {o_hi, o_lo},     64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Directed arithmetic cases
        do_op(2'b00, 32'd7,         32'hFFFF_FFFD, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0);
        do_op(2'b11, 32'd100,       32'd0,         1'b0);
        do_op(2'b10, 32'hFFFF_FF00, 32'd0,         1'b0);
        do_op(2'b10, 32'd100,       32'hFFFF_FFF9, 1'b0);

        // Mixed pseudo-random operands across all opcodes
        for (int i = 0; i < 6; i++) begin
            logic [31:0] rs;
            logic [31:0] rt;
            rs = $urandom;
            rt = $urandom >> $urandom_range(0, 28);
            do_op(2'(i % 4), rs, rt, 1'b0);
        end

        // MTHI/MTLO preload, then flush a MULT mid-calculation
        @(posedge i_clk); #1;
        i_wr_hi = 1'b1;
        i_wdata = 32'h0000_1234;
        @(posedge i_clk); #1;
        i_wr_hi = 1'b0;
        check_val("mthi", {32'h0, o_hi}, 64'h1234);
        i_wr_lo = 1'b1;
        i_wdata = 32'h0000_5678;
        @(posedge i_clk); #1;
        i_wr_lo = 1'b0;
        check_val("mtlo", {32'h0, o_lo}, 64'h5678);
        i_start   = 1'b1;
        i_md_op   = 2'b00;
        i_rs_data = 32'd3;
        i_rt_data = 32'd4;
        repeat (10) begin
            @(posedge i_clk); #1;
        end
        i_flush = 1'b1;
        i_start = 1'b0;
        #1;
        check_val("flush_stall_calc", {63'h0, o_stall}, 64'd1);
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check_val("flush_busy",  {63'h0, o_busy},  64'd0);
        check_val("flush_stall", {63'h0, o_stall}, 64'd0);
        repeat (30) @(posedge i_clk);
        #1;
        check_val("flush_hi", {32'h0, o_hi}, 64'h1234);
        check_val("flush_lo", {32'h0, o_lo}, 64'h5678);

        // Asynchronous reset in the middle of CALC
        @(posedge i_clk); #1;
        i_start   = 1'b1;
        i_md_op   = 2'b10;
        i_rs_data = 32'h1234_5678;
        i_rt_data = 32'd7;
        repeat (15) @(posedge i_clk);
        #3;
        check_val("pre_rst_busy", {63'h0, o_busy}, 64'd1);
        i_rst_n = 1'b0;
        i_start = 1'b0;
        #1;
        check_val("arst_stall", {63'h0, o_stall}, 64'd0);
        check_val("arst_busy",  {63'h0, o_busy},  64'd0);
        check_val("arst_done",  {63'h0, o_done},  64'd0);
        check_val("arst_hilo",  {o_hi, o_lo},     64'd0);
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;

        // Signed overflow after reset release
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Back-to-back MULTs; the second takes an MTLO on its result edge
        do_op(2'b00, 32'd5,         32'd6,         1'b0);
        do_op(2'b00, 32'hFFFF_0001, 32'h0001_2345, 1'b1);
        @(posedge i_clk); #1;
        check_val("mtlo_wins_lo", {32'h0, o_lo}, 64'hAA);
        check_val("b2b_idle", {63'h0, o_busy}, 64'd0);

        repeat (3) @(posedge i_clk);
        #1;
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        check_val("done_count", 64'(n_done), 64'(n_push));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_ex_muldiv_ctrl
`default_nettype wire

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Multi-cycle multiply/divide controller for the EX stage. It executes MULT, MULTU, DIV and DIVU iteratively and owns the HI/LO register pair. While an operation runs it asserts a stall so the hazard logic freezes IF/ID/EX. It sits beside the single-cycle ALU and takes the same forwarded RS/RT operands as ALU inputs A and B (before the ALU-source mux).

Parameters:
NB_REG, 32, operand/register width
NB_CNT, 6, iteration counter width (must hold NB_REG)
NB_MDOP, 2, mul/div opcode width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  EX instruction is a mul/div op
i_md_op  in  NB_MDOP  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
i_rs_data  in  NB_REG  forwarded RS operand (multiplicand/dividend)
i_rt_data  in  NB_REG  forwarded RT operand (multiplier/divisor)
i_wr_hi  in  1  MTHI write enable
i_wr_lo  in  1  MTLO write enable
i_wdata  in  NB_REG  MTHI/MTLO data (forwarded RS)
i_flush  in  1  synchronous abort (pipeline flush)
o_stall  out  1  freeze IF/ID/EX, combinational
o_busy  out  1  registered, state != IDLE
o_done  out  1  one-cycle pulse, HI/LO updated this edge
o_hi  out  NB_REG  HI register
o_lo  out  NB_REG  LO register

Behaviour:
- Reset: state IDLE; o_hi, o_lo = 0; o_busy = 0; o_done = 0; counter and accumulators = 0.
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, i_start=1 (and i_flush=0):
  - latch op, magnitudes |rs| and |rt| (signed ops only), and the sign flags;
  - counter = 0; go to CALC.
- CALC: one radix-2 iteration per cycle.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring divide, 32-bit remainder/quotient.
  - After NB_REG iterations (counter == NB_REG-1) go to FIX.
- FIX: sign correction.
  - Product is negated (64-bit) if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Go to DONE.
- DONE: {HI,LO} are written at the DONE-entry edge; o_done = 1 for one cycle; next state IDLE.
- Latency: start accepted at edge 0; o_done is high in cycle 34 (32 CALC + FIX + DONE). Results are visible on o_hi/o_lo in the DONE cycle.
- o_stall = (IDLE & i_start & ~i_flush) | CALC | FIX. It is low in DONE so the held instruction advances.
- i_start is ignored outside IDLE; the held instruction keeps i_start high during CALC without retriggering.
- Divide by zero (rt = 0), no trap, normal latency:
  - LO = 0xFFFFFFFF; HI = rs (raw dividend);
  - the signed sign fix is skipped.
- Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural outcome of the magnitude algorithm).
- MTHI/MTLO: the write applies at the next edge in any state.
  - If it lands on the same edge as the DONE result write, the MTHI/MTLO write wins for that register.
  - A write coincident with start is applied, then overwritten at DONE.
- i_flush: any state -> IDLE next edge; HI/LO unchanged; o_done stays 0. A flush in DONE still commits HI/LO (the result is already architecturally due).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.
- Outputs o_hi/o_lo are registers. MFHI/MFLO reads are combinational from them; there is no bypass of an in-flight result.

Decomposition:
- Package muldiv_pkg:
  - MD_MULT, MD_MULTU, MD_DIV, MD_DIVU opcode localparams;
  - FSM state encodings (IDLE=0, CALC=1, FIX=2, DONE=3);
  - DIV0_LO constant 0xFFFFFFFF.
- Sub-module ex_muldiv_core: per-iteration datapath step (shift-add / restoring subtract), pure combinational.
- The controller owns the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3), start pulse held until o_stall=0 -> o_done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_stall high cycles 0-33.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=0x00000064.
- Preload via MTHI 0x1234, MTLO 0x5678; start MULT 3*4; assert i_flush at cycle 10 -> IDLE next cycle, no o_done, HI=0x1234, LO=0x5678 unchanged.
- Deassert i_rst_n asynchronously mid-CALC (cycle 15) -> o_stall/o_busy/o_done=0, HI=LO=0 immediately; a new DIV 0x80000000 / 0xFFFFFFFF after release -> LO=0x80000000, HI=0.
- Back-to-back: a second MULT presented the cycle after DONE -> accepted, no lost or duplicate o_done; MTLO 0xAA asserted on the result edge -> LO=0xAA, HI from the product.
